// File: rtl/l2_demux_pkg.sv
// Shared types and helpers for the L2 interleaved bank demux.
// Tag layout is fixed-width so the FIFO and the top agree for any bank count up to 256.
package l2_demux_pkg;

  localparam int unsigned TAG_BANK_W = 8;
  localparam logic [31:0] ERR_RDATA  = 32'hBADA_CCE5;

  typedef struct packed {
    logic                  err;
    logic [TAG_BANK_W-1:0] bank;
  } tag_t;

  function automatic int unsigned bank_bits(input int unsigned n);
    return $clog2(n);
  endfunction

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/l2_demux_tag_fifo.sv
// In-order tag FIFO tracking outstanding requests; head is visible combinationally.
// Pointers wrap naturally because DEPTH is a power of two.
module l2_demux_tag_fifo
  import l2_demux_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  tag_t data_i,
  output tag_t head_o,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned PW = bank_bits(DEPTH);
  localparam int unsigned CW = cnt_width(DEPTH);

  tag_t          mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;
  assign head_o  = mem_q[rptr_q];

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_push) wptr_d = wptr_q + PW'(1);
    if (do_pop)  rptr_d = rptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset: an entry is only read after it has been written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/l2_intl_bank_demux.sv
// Routes one TCDM master port to NB_BANKS word-interleaved banks and returns responses in order.
// Optional L2_DEMUX_ERR_RESP_EN: out-of-region addresses get a local error response.
module l2_intl_bank_demux
  import l2_demux_pkg::*;
#(
  parameter int unsigned NB_BANKS        = 4,
  parameter int unsigned BANK_SIZE       = 32768,
  parameter logic [31:0] BASE_ADDR       = 32'h1C01_0000,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         m_req_i,
  input  logic                         m_wen_i,
  input  logic [31:0]                  m_add_i,
  input  logic [31:0]                  m_wdata_i,
  input  logic [3:0]                   m_be_i,
  output logic                         m_gnt_o,
  output logic                         m_r_valid_o,
  output logic [31:0]                  m_r_rdata_o,
  output logic                         m_r_opc_o,
  output logic [NB_BANKS-1:0]          b_req_o,
  output logic [NB_BANKS-1:0][31:0]    b_add_o,
  output logic [NB_BANKS-1:0][31:0]    b_wdata_o,
  output logic [NB_BANKS-1:0]          b_wen_o,
  output logic [NB_BANKS-1:0][3:0]     b_be_o,
  input  logic [NB_BANKS-1:0]          b_gnt_i,
  input  logic [NB_BANKS-1:0]          b_r_valid_i,
  input  logic [NB_BANKS-1:0]          b_r_opc_i,
  input  logic [NB_BANKS-1:0][31:0]    b_r_rdata_i,
  output logic                         err_o
);

  localparam int unsigned BB = bank_bits(NB_BANKS);

  logic [BB-1:0]       sel;
  logic [BB-1:0]       head_bank;
  logic                in_range;
  logic                accept;
  logic                full, empty;
  tag_t                push_tag, head;
  logic [NB_BANKS-1:0] exp_mask;
  logic                stray;
  logic                err_q, err_d;
  logic                post_rst_q;
  logic                unused_head_hi;

  assign sel = m_add_i[2+BB-1:2];

`ifdef L2_DEMUX_ERR_RESP_EN
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(NB_BANKS * BANK_SIZE * 4);
  assign in_range = ({1'b0, m_add_i} >= {1'b0, BASE_ADDR}) && ({1'b0, m_add_i} < END_ADDR);
`else
  assign in_range = 1'b1;
`endif

  assign b_add_o   = {NB_BANKS{m_add_i}};
  assign b_wdata_o = {NB_BANKS{m_wdata_i}};
  assign b_wen_o   = {NB_BANKS{m_wen_i}};
  assign b_be_o    = {NB_BANKS{m_be_i}};

  // Request path: outputs are forced idle while reset is asserted.
  assign accept  = ~rst_i & m_req_i & ~full;
  assign m_gnt_o = accept & (~in_range | b_gnt_i[sel]);

  always_comb begin
    b_req_o = '0;
    if (accept & in_range) b_req_o[sel] = 1'b1;
  end

  assign push_tag.err  = ~in_range;
  assign push_tag.bank = TAG_BANK_W'(sel);

  l2_demux_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (m_gnt_o),
    .pop_i   (m_r_valid_o),
    .data_i  (push_tag),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  assign head_bank      = head.bank[BB-1:0];
  assign unused_head_hi = |(head.bank >> BB);

  // Response path: only the head's bank may answer; an error tag answers locally.
  always_comb begin
    exp_mask    = '0;
    m_r_valid_o = 1'b0;
    m_r_rdata_o = '0;
    m_r_opc_o   = 1'b0;
    if (~rst_i & ~empty) begin
      if (head.err) begin
        m_r_valid_o = 1'b1;
        m_r_rdata_o = ERR_RDATA;
        m_r_opc_o   = 1'b1;
      end else begin
        exp_mask[head_bank] = 1'b1;
        if (b_r_valid_i[head_bank]) begin
          m_r_valid_o = 1'b1;
          m_r_rdata_o = b_r_rdata_i[head_bank];
          m_r_opc_o   = b_r_opc_i[head_bank];
        end
      end
    end
  end

  // Late responses from before a reset are expected in the first cycle out of it.
  assign stray = |(b_r_valid_i & ~exp_mask);
  assign err_d = err_q | (stray & ~post_rst_q);
  assign err_o = err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_q      <= 1'b0;
      post_rst_q <= 1'b1;
    end else begin
      err_q      <= err_d;
      post_rst_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_l2_intl_bank_demux.sv
// Directed bench for l2_intl_bank_demux; the error-response step is built when L2_DEMUX_ERR_RESP_EN is defined.
module tb_l2_intl_bank_demux;

  localparam logic [31:0] BASE = 32'h1C01_0000;

  logic              clk = 1'b0;
  logic              rst_i;
  logic              m_req_i, m_wen_i;
  logic [31:0]       m_add_i, m_wdata_i;
  logic [3:0]        m_be_i;
  logic              m_gnt_o, m_r_valid_o, m_r_opc_o;
  logic [31:0]       m_r_rdata_o;
  logic [3:0]        b_req_o, b_wen_o;
  logic [3:0][31:0]  b_add_o, b_wdata_o;
  logic [3:0][3:0]   b_be_o;
  logic [3:0]        b_gnt_i, b_r_valid_i, b_r_opc_i;
  logic [3:0][31:0]  b_r_rdata_i;
  logic              err_o;

  int total = 0;
  int bad   = 0;

  l2_intl_bank_demux dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .m_req_i     (m_req_i),
    .m_wen_i     (m_wen_i),
    .m_add_i     (m_add_i),
    .m_wdata_i   (m_wdata_i),
    .m_be_i      (m_be_i),
    .m_gnt_o     (m_gnt_o),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .m_r_opc_o   (m_r_opc_o),
    .b_req_o     (b_req_o),
    .b_add_o     (b_add_o),
    .b_wdata_o   (b_wdata_o),
    .b_wen_o     (b_wen_o),
    .b_be_o      (b_be_o),
    .b_gnt_i     (b_gnt_i),
    .b_r_valid_i (b_r_valid_i),
    .b_r_opc_i   (b_r_opc_i),
    .b_r_rdata_i (b_r_rdata_i),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] cnt();
    return 32'(dut.u_fifo.count_q);
  endfunction

  initial begin
    rst_i = 1'b1; m_req_i = 1'b0; m_wen_i = 1'b1; m_add_i = '0; m_wdata_i = '0; m_be_i = 4'hF;
    b_gnt_i = 4'hF; b_r_valid_i = '0; b_r_opc_i = '0; b_r_rdata_i = '0;

    // Reset values
    @(negedge clk); #1;
    chk("rst_gnt", 32'(m_gnt_o), 0);
    chk("rst_rvalid", 32'(m_r_valid_o), 0);
    chk("rst_rdata", m_r_rdata_o, 0);
    chk("rst_breq", 32'(b_req_o), 0);
    @(negedge clk); rst_i = 1'b0; #1;
    chk("rst_err", 32'(err_o), 0);
    chk("rst_cnt", cnt(), 0);

    // Single read to bank 2
    @(negedge clk); m_req_i = 1'b1; m_add_i = BASE + 32'h8; #1;
    chk("single_breq", 32'(b_req_o), 32'b0100);
    chk("single_gnt", 32'(m_gnt_o), 1);
    chk("single_badd", b_add_o[2], BASE + 32'h8);
    @(negedge clk); m_req_i = 1'b0; b_r_valid_i = 4'b0100; b_r_rdata_i[2] = 32'hCAFE_0001; #1;
    chk("single_rvalid", 32'(m_r_valid_o), 1);
    chk("single_rdata", m_r_rdata_o, 32'hCAFE_0001);
    chk("single_opc", 32'(m_r_opc_o), 0);
    @(negedge clk); b_r_valid_i = '0; #1;
    chk("single_cnt", cnt(), 0);

    // Back-to-back interleaved reads
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      m_req_i = (i < 8); m_add_i = BASE + 32'(4 * i); b_r_valid_i = '0;
      if (i > 0) begin
        b_r_valid_i[(i-1)%4] = 1'b1;
        b_r_rdata_i[(i-1)%4] = 32'hD000_0000 + 32'(i - 1);
      end
      #1;
      if (i < 8) begin
        chk("b2b_breq", 32'(b_req_o), 32'(1 << (i % 4)));
        chk("b2b_gnt", 32'(m_gnt_o), 1);
      end
      if (i > 0) begin
        chk("b2b_rvalid", 32'(m_r_valid_o), 1);
        chk("b2b_rdata", m_r_rdata_o, 32'hD000_0000 + 32'(i - 1));
      end
      chk("b2b_cnt", cnt(), (i > 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk); b_r_valid_i = '0; #1;
    chk("b2b_cnt_end", cnt(), 0);

    // Full stall: four outstanding, fifth waits for a pop
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); m_req_i = 1'b1; m_add_i = BASE + 32'(4 * i); #1;
      chk("full_gnt", 32'(m_gnt_o), 1);
    end
    @(negedge clk); m_add_i = BASE + 32'h10; #1;
    chk("full_5th_gnt", 32'(m_gnt_o), 0);
    chk("full_5th_breq", 32'(b_req_o), 0);
    chk("full_cnt", cnt(), 4);
    @(negedge clk); b_r_valid_i = 4'b0001; b_r_rdata_i[0] = 32'h1111_0000; #1;
    chk("full_pop_rvalid", 32'(m_r_valid_o), 1);
    chk("full_pop_rdata", m_r_rdata_o, 32'h1111_0000);
    chk("full_pop_gnt", 32'(m_gnt_o), 0);
    @(negedge clk); b_r_valid_i = '0; #1;
    chk("full_5th_gnt_after", 32'(m_gnt_o), 1);
    chk("full_5th_breq_after", 32'(b_req_o), 32'b0001);
    chk("full_cnt_after_pop", cnt(), 3);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); m_req_i = 1'b0;
      b_r_valid_i = '0; b_r_valid_i[k % 4] = 1'b1; b_r_rdata_i[k % 4] = 32'h2222_0000 + 32'(k); #1;
      chk("drain_rvalid", 32'(m_r_valid_o), 1);
      chk("drain_rdata", m_r_rdata_o, 32'h2222_0000 + 32'(k));
    end
    @(negedge clk); b_r_valid_i = '0; #1;
    chk("drain_cnt", cnt(), 0);
    chk("drain_err", 32'(err_o), 0);

    // Bank 1 back-pressure
    @(negedge clk); b_gnt_i = 4'b1101; m_req_i = 1'b1; m_add_i = BASE + 32'h4;
    for (int j = 0; j < 3; j++) begin
      #1;
      chk("bp_breq", 32'(b_req_o), 32'b0010);
      chk("bp_gnt", 32'(m_gnt_o), 0);
      chk("bp_cnt", cnt(), 0);
      @(negedge clk);
    end
    b_gnt_i = 4'hF; #1;
    chk("bp_release_gnt", 32'(m_gnt_o), 1);
    @(negedge clk); m_req_i = 1'b0; b_r_valid_i = 4'b0010; b_r_rdata_i[1] = 32'h3333_0001; #1;
    chk("bp_rdata", m_r_rdata_o, 32'h3333_0001);

    // Stray response while head is bank 0
    @(negedge clk); b_r_valid_i = '0; m_req_i = 1'b1; m_add_i = BASE; #1;
    chk("stray_gnt", 32'(m_gnt_o), 1);
    @(negedge clk); m_req_i = 1'b0; b_r_valid_i = 4'b1000; b_r_rdata_i[3] = 32'hDEAD_BEEF; #1;
    chk("stray_rvalid", 32'(m_r_valid_o), 0);
    chk("stray_err_before", 32'(err_o), 0);
    @(negedge clk); b_r_valid_i = 4'b0001; b_r_rdata_i[0] = 32'h4444_0000; #1;
    chk("stray_err", 32'(err_o), 1);
    chk("stray_cnt", cnt(), 1);
    chk("stray_head_rdata", m_r_rdata_o, 32'h4444_0000);
    @(negedge clk); b_r_valid_i = '0; #1;
    chk("stray_cnt_end", cnt(), 0);

`ifdef L2_DEMUX_ERR_RESP_EN
    // Out-of-region read answered locally
    @(negedge clk); m_req_i = 1'b1; m_add_i = 32'h1C09_0000; #1;
    chk("errresp_breq", 32'(b_req_o), 0);
    chk("errresp_gnt", 32'(m_gnt_o), 1);
    chk("errresp_rvalid_early", 32'(m_r_valid_o), 0);
    @(negedge clk); m_req_i = 1'b0; #1;
    chk("errresp_rvalid", 32'(m_r_valid_o), 1);
    chk("errresp_opc", 32'(m_r_opc_o), 1);
    chk("errresp_rdata", m_r_rdata_o, 32'hBADA_CCE5);
    @(negedge clk); #1;
    chk("errresp_cnt", cnt(), 0);
`endif

    // Reset with three outstanding requests
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); m_req_i = 1'b1; m_add_i = BASE + 32'(4 * i); #1;
      chk("rmid_gnt", 32'(m_gnt_o), 1);
    end
    @(negedge clk); m_req_i = 1'b0; #1;
    chk("rmid_cnt_before", cnt(), 3);
    @(negedge clk); rst_i = 1'b1; #1;
    chk("rmid_rst_gnt", 32'(m_gnt_o), 0);
    @(negedge clk); rst_i = 1'b0; b_r_valid_i = 4'b0001; b_r_rdata_i[0] = 32'h5555_0000; #1;
    chk("rmid_cnt", cnt(), 0);
    chk("rmid_rvalid", 32'(m_r_valid_o), 0);
    chk("rmid_rdata", m_r_rdata_o, 0);
    chk("rmid_err_cleared", 32'(err_o), 0);
    @(negedge clk); b_r_valid_i = '0; #1;
    chk("rmid_late_err", 32'(err_o), 0);

    // Response with an empty FIFO outside the post-reset cycle
    @(negedge clk); b_r_valid_i = 4'b0010; #1;
    chk("empty_resp_rvalid", 32'(m_r_valid_o), 0);
    @(negedge clk); b_r_valid_i = '0; #1;
    chk("empty_resp_err", 32'(err_o), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
